// File: rtl/serv_alu_xw.sv
// serv_alu_xw: digit-serial ALU, W bits/cycle, LSB first, valid/ready in and out.
// Ports: clk, i_rst_n, i_valid/o_ready, i_op, i_rs1, i_op_b, o_valid/i_ready, o_rd, o_cmp, o_busy.
module serv_alu_xw #(
  parameter int XLEN = 32,
  parameter int W    = 1
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_rd,
  output logic            o_cmp,
  output logic            o_busy
);

  localparam int N  = XLEN / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_NE   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // r_a doubles as the result register: result digits enter at the
  // MSB end while operand digits leave at the LSB end.
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [3:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_eq;
  logic [XLEN-1:0] r_rd;
  logic            r_cmp;

  logic            w_accept;
  logic            w_last;
  logic            w_sub;
  logic [W-1:0]    w_a_dig;
  logic [W-1:0]    w_b_dig;
  logic [W-1:0]    w_b_op;
  logic [W:0]      w_sum;
  logic            w_cout;
  logic            w_eq_fin;
  logic            w_lt_s;
  logic            w_lt_u;
  logic [W-1:0]    w_dig;
  logic [XLEN-1:0] w_a_nxt;
  logic [XLEN-1:0] w_b_nxt;
  logic [XLEN-1:0] w_rd_fin;
  logic            w_cmp_fin;

  function automatic logic f_sub(input logic [3:0] op);
    return op inside {OP_SUB, OP_SLT, OP_SLTU, OP_EQ, OP_NE};
  endfunction

  assign w_accept = (r_state == S_IDLE) && i_valid;
  assign w_last   = (r_cnt == LAST);
  assign w_sub    = f_sub(r_op);
  assign w_a_dig  = r_a[W-1:0];
  assign w_b_dig  = r_b[W-1:0];
  assign w_b_op   = w_sub ? ~w_b_dig : w_b_dig;
  assign w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_op}
                  + {{W{1'b0}}, r_carry};
  assign w_cout   = w_sum[W];
  assign w_eq_fin = r_eq & (w_a_dig == w_b_dig);
  // Signed compare: sign bit of the sign-extended difference.
  assign w_lt_s   = w_a_dig[W-1] ^ ~w_b_dig[W-1] ^ w_cout;
  assign w_lt_u   = ~w_cout;

  generate
    if (W == XLEN) begin : g_full
      assign w_a_nxt = w_dig;
      assign w_b_nxt = r_b;
    end else begin : g_part
      assign w_a_nxt = {w_dig, r_a[XLEN-1:W]};
      assign w_b_nxt = {{W{1'b0}}, r_b[XLEN-1:W]};
    end
  endgenerate

  always_comb begin
    w_dig = '0;
    case (r_op)
      OP_ADD,
      OP_SUB:  w_dig = w_sum[W-1:0];
      OP_XOR:  w_dig = w_a_dig ^ w_b_dig;
      OP_OR:   w_dig = w_a_dig | w_b_dig;
      OP_AND:  w_dig = w_a_dig & w_b_dig;
      default: w_dig = '0;
    endcase
  end

  always_comb begin
    w_rd_fin  = '0;
    w_cmp_fin = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB,
      OP_XOR, OP_OR,
      OP_AND: w_rd_fin = w_a_nxt;
      OP_SLT: begin
        w_rd_fin  = {{(XLEN-1){1'b0}}, w_lt_s};
        w_cmp_fin = w_lt_s;
      end
      OP_SLTU: begin
        w_rd_fin  = {{(XLEN-1){1'b0}}, w_lt_u};
        w_cmp_fin = w_lt_u;
      end
      OP_EQ:   w_cmp_fin = w_eq_fin;
      OP_NE:   w_cmp_fin = ~w_eq_fin;
      default: begin
        w_rd_fin  = '0;
        w_cmp_fin = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_IDLE);
    o_busy  = (r_state == S_RUN);
    o_valid = (r_state == S_DONE);
    o_rd    = r_rd;
    o_cmp   = r_cmp;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_eq    <= 1'b0;
      r_rd    <= '0;
      r_cmp   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_rs1;
      r_b     <= i_op_b;
      r_op    <= i_op;
      r_cnt   <= '0;
      r_carry <= f_sub(i_op);
      r_eq    <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_carry <= w_cout;
      r_eq    <= w_eq_fin;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) begin
        r_rd  <= w_rd_fin;
        r_cmp <= w_cmp_fin;
      end
    end
  end

endmodule

// File: tb/tb_serv_alu_xw.sv
// tb_serv_alu_xw: directed bench for serv_alu_xw at W = 1, 4, 8, 32, 2.
// Expected values are hand-computed constants; checks are immediate assertions.
module tb_serv_alu_xw;

  localparam int NI = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NI];
  logic        vin   [NI];
  logic        rdy   [NI];
  logic        ordy  [NI];
  logic        oval  [NI];
  logic        obusy [NI];
  logic        ocmp  [NI];
  logic [3:0]  op    [NI];
  logic [31:0] a     [NI];
  logic [31:0] b     [NI];
  logic [31:0] ord   [NI];

  int total = 0;
  int bad   = 0;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int WG = (g == 0) ? 1 : (g == 1) ? 4 :
                          (g == 2) ? 8 : (g == 3) ? 32 : 2;
      serv_alu_xw #(.XLEN(32), .W(WG)) u_dut (
        .clk     (clk),
        .i_rst_n (rst_n[g]),
        .i_valid (vin[g]),
        .o_ready (ordy[g]),
        .i_op    (op[g]),
        .i_rs1   (a[g]),
        .i_op_b  (b[g]),
        .o_valid (oval[g]),
        .i_ready (rdy[g]),
        .o_rd    (ord[g]),
        .o_cmp   (ocmp[g]),
        .o_busy  (obusy[g])
      );
    end
  endgenerate

  function automatic int nof(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 4;
      3:       return 1;
      default: return 16;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int i, input string tag,
                        input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] erd, input logic ecmp);
    int n;
    logic [31:0] prev;
    n = 0;
    while (!ordy[i] && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_ready"}, 32'(ordy[i]), 32'd1);
    prev  = ord[i];
    vin[i] = 1'b1;
    op[i]  = o;
    a[i]   = x;
    b[i]   = y;
    tick;
    vin[i] = 1'b0;
    a[i]   = ~x;
    b[i]   = ~y;
    chk({tag, "_busy"}, 32'(obusy[i]), 32'd1);
    chk({tag, "_hold"}, ord[i], prev);
    n = 0;
    while (!oval[i] && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(nof(i)));
    chk({tag, "_rd"}, ord[i], erd);
    chk({tag, "_cmp"}, 32'(ocmp[i]), 32'(ecmp));
    rdy[i] = 1'b1;
    tick;
    rdy[i] = 1'b0;
    chk({tag, "_vdrop"}, 32'(oval[i]), 32'd0);
    chk({tag, "_rdyup"}, 32'(ordy[i]), 32'd1);
    chk({tag, "_keep"}, ord[i], erd);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      vin[i]   = 1'b0;
      rdy[i]   = 1'b0;
      op[i]    = 4'd0;
      a[i]     = '0;
      b[i]     = '0;
    end
    tick;
    tick;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    tick;
    chk("rst_ready", 32'(ordy[0]), 32'd1);
    chk("rst_valid", 32'(oval[0]), 32'd0);
    chk("rst_busy",  32'(obusy[0]), 32'd0);
    chk("rst_rd",    ord[0], 32'd0);
    chk("rst_cmp",   32'(ocmp[0]), 32'd0);

    run_op(0, "w1_add", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_op(1, "w4_slt", 4'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b1);
    run_op(1, "w4_sltu", 4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0);
    run_op(2, "w8_sub", 4'd1, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0);
    run_op(2, "w8_eq", 4'd7, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1);
    run_op(2, "w8_ne", 4'd8, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0);
    run_op(2, "w8_ne2", 4'd8, 32'h1234_5678, 32'h1234_5679, 32'h0, 1'b1);
    run_op(2, "w8_rsv", 4'd9, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b0);
    run_op(3, "w32_and", 4'd6, 32'hF0F0_AAAA, 32'h0FF0_FFFF, 32'h00F0_AAAA, 1'b0);
    run_op(3, "w32_or", 4'd5, 32'hF0F0_AAAA, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0);
    run_op(3, "w32_xor", 4'd4, 32'hF0F0_AAAA, 32'h0FF0_FFFF, 32'hFF00_5555, 1'b0);
    run_op(4, "w2_slt_n", 4'd2, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b1);

    // Backpressure on the W=2 instance.
    vin[4] = 1'b1;
    op[4]  = 4'd0;
    a[4]   = 32'h1234_5678;
    b[4]   = 32'h1111_1111;
    tick;
    vin[4] = 1'b0;
    n = 0;
    while (!oval[4] && n < 100) begin
      tick;
      n++;
    end
    chk("bp_lat", 32'(n), 32'd16);
    held = 32'h2345_6789;
    for (int k = 0; k < 10; k++) begin
      chk("bp_rd", ord[4], held);
      chk("bp_valid", 32'(oval[4]), 32'd1);
      chk("bp_ready", 32'(ordy[4]), 32'd0);
      tick;
    end
    rdy[4] = 1'b1;
    tick;
    rdy[4] = 1'b0;
    chk("bp_release", 32'(ordy[4]), 32'd1);

    // i_ready held high through RUN: hand-off at the first valid cycle.
    rdy[4] = 1'b1;
    vin[4] = 1'b1;
    op[4]  = 4'd1;
    a[4]   = 32'h10;
    b[4]   = 32'h3;
    tick;
    vin[4] = 1'b0;
    n = 0;
    while (!oval[4] && n < 100) begin
      tick;
      n++;
    end
    chk("early_rdy_lat", 32'(n), 32'd16);
    chk("early_rdy_rd", ord[4], 32'hD);
    tick;
    rdy[4] = 1'b0;
    chk("early_rdy_done", 32'(oval[4]), 32'd0);
    chk("early_rdy_idle", 32'(ordy[4]), 32'd1);

    // Give the W=1 instance a nonzero result before the abort.
    run_op(0, "w1_sltu", 4'd3, 32'h1, 32'h2, 32'h1, 1'b1);

    vin[0] = 1'b1;
    op[0]  = 4'd0;
    a[0]   = 32'd100;
    b[0]   = 32'd200;
    tick;
    vin[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    chk("abort_busy", 32'(obusy[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("abort_ready", 32'(ordy[0]), 32'd1);
    chk("abort_valid", 32'(oval[0]), 32'd0);
    chk("abort_busy0", 32'(obusy[0]), 32'd0);
    chk("abort_rd", ord[0], 32'd0);
    chk("abort_cmp", 32'(ocmp[0]), 32'd0);
    tick;
    rst_n[0] = 1'b1;
    tick;
    run_op(0, "post_add", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
